// File: rtl/prgrom_loader_if.sv
// ==== prgrom_loader_if : UART-byte input, instruction-memory write and status bundle (rev 1.0) ====
`default_nettype none

interface prgrom_loader_if #(
  parameter int ADDR_WIDTH = 14
) ();
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [15:0]           words_written;

  // The host/UART side drives the master modport; the loader uses the slave modport.
  modport master (
    output start, rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_written
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_written
  );
endinterface

`default_nettype wire

// File: rtl/prgrom_loader.sv
// ==== prgrom_loader : loads a length-prefixed big-endian word image into instruction memory (rev 1.0) ====
`default_nettype none

module prgrom_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           clock,
  input  logic           reset,
  prgrom_loader_if.slave bus
);

  localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]         c_DEPTH    = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                state_q;
  logic [15:0]           len_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           asm_q;
  logic [c_TMO_W-1:0]    tmo_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  cpu_hold_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [15:0]           words_written_q;

  logic [15:0]           len_d;
  logic                  tmo_hit_d;
  logic                  last_write_d;

  assign len_d        = {len_q[15:8], bus.rx_data};
  assign tmo_hit_d    = busy_q && !bus.rx_valid && (tmo_q == c_TMO_LAST);
  // words_written already counts the word being written during the mem_we cycle
  assign last_write_d = mem_we_q && (words_written_q == len_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      byte_cnt_q      <= '0;
      asm_q           <= '0;
      tmo_q           <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cpu_hold_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      words_written_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (busy_q) begin
        tmo_q <= bus.rx_valid ? '0 : tmo_q + c_TMO_W'(1);
      end

      if (tmo_hit_d) begin
        state_q <= S_ERR;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
              state_q         <= S_LEN_HI;
              cpu_hold_q      <= 1'b1;
              busy_q          <= 1'b1;
              done_q          <= 1'b0;
              error_q         <= 1'b0;
              words_written_q <= '0;
              byte_cnt_q      <= '0;
              tmo_q           <= '0;
            end
          end
          S_LEN_HI: begin
            if (bus.rx_valid) begin
              len_q[15:8] <= bus.rx_data;
              state_q     <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (bus.rx_valid) begin
              len_q <= len_d;
              if (len_d == 16'd0) begin
                state_q    <= S_DONE;
                cpu_hold_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end else if ({1'b0, len_d} > c_DEPTH) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
              end else begin
                state_q    <= S_DATA;
                byte_cnt_q <= '0;
              end
            end
          end
          S_DATA: begin
            if (last_write_d) begin
              state_q    <= S_DONE;
              cpu_hold_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if (bus.rx_valid) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                mem_we_q        <= 1'b1;
                mem_wdata_q     <= {asm_q, bus.rx_data};
                mem_addr_q      <= ADDR_WIDTH'(words_written_q);
                words_written_q <= words_written_q + 16'd1;
              end else begin
                asm_q <= {asm_q[15:0], bus.rx_data};
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.cpu_hold      = cpu_hold_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.words_written = words_written_q;

endmodule

`default_nettype wire

// File: tb/tb_prgrom_loader.sv
// ==== tb_prgrom_loader : directed self-checking bench for prgrom_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=20) (rev 1.0) ====
`default_nettype none

module tb_prgrom_loader;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  prgrom_loader_if #(.ADDR_WIDTH(4)) bus ();

  prgrom_loader #(
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          we_cnt = 0;
  logic [3:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  // Write log: every cycle with mem_we high is one recorded write.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      if (we_cnt < 64) begin
        wr_addr[we_cnt] = bus.mem_addr;
        wr_data[we_cnt] = bus.mem_wdata;
      end
      we_cnt++;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && bus.error !== 1'b1 && cyc < max_cyc) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL reset.mem_we got %b exp 0", bus.mem_we); else n_pass++;
    n_chk++; if (bus.mem_addr !== 4'd0) $display("FAIL reset.mem_addr got %h exp 0", bus.mem_addr); else n_pass++;
    n_chk++; if (bus.mem_wdata !== 32'd0) $display("FAIL reset.mem_wdata got %h exp 0", bus.mem_wdata); else n_pass++;
    n_chk++; if (bus.cpu_hold !== 1'b0) $display("FAIL reset.cpu_hold got %b exp 0", bus.cpu_hold); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset.busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset.done got %b exp 0", bus.done); else n_pass++;
    n_chk++; if (bus.error !== 1'b0) $display("FAIL reset.error got %b exp 0", bus.error); else n_pass++;
    n_chk++; if (bus.words_written !== 16'd0) $display("FAIL reset.words_written got %0d exp 0", bus.words_written); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load(input string name, input int gap);
    logic [7:0] img [0:9];
    int base, cyc;
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    base = we_cnt;
    pulse_start();
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL %s.busy_after_start got %b exp 1", name, bus.busy); else n_pass++;
    n_chk++; if (bus.cpu_hold !== 1'b1) $display("FAIL %s.hold_after_start got %b exp 1", name, bus.cpu_hold); else n_pass++;
    for (int i = 0; i < 10; i++) send(img[i], gap);
    wait_end(100, cyc);
    n_chk++; if (we_cnt - base !== 2) $display("FAIL %s.write_count got %0d exp 2", name, we_cnt - base); else n_pass++;
    n_chk++; if (wr_addr[base] !== 4'd0) $display("FAIL %s.addr0 got %h exp 0", name, wr_addr[base]); else n_pass++;
    n_chk++; if (wr_data[base] !== 32'h12345678) $display("FAIL %s.data0 got %h exp 12345678", name, wr_data[base]); else n_pass++;
    n_chk++; if (wr_addr[base+1] !== 4'd1) $display("FAIL %s.addr1 got %h exp 1", name, wr_addr[base+1]); else n_pass++;
    n_chk++; if (wr_data[base+1] !== 32'h9ABCDEF0) $display("FAIL %s.data1 got %h exp 9abcdef0", name, wr_data[base+1]); else n_pass++;
    n_chk++; if (bus.done !== 1'b1) $display("FAIL %s.done got %b exp 1", name, bus.done); else n_pass++;
    n_chk++; if (bus.error !== 1'b0) $display("FAIL %s.error got %b exp 0", name, bus.error); else n_pass++;
    n_chk++; if (bus.cpu_hold !== 1'b0) $display("FAIL %s.cpu_hold got %b exp 0", name, bus.cpu_hold); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL %s.busy got %b exp 0", name, bus.busy); else n_pass++;
    n_chk++; if (bus.words_written !== 16'd2) $display("FAIL %s.words_written got %0d exp 2", name, bus.words_written); else n_pass++;
    n_chk++; if (bus.mem_addr !== 4'd1 || bus.mem_wdata !== 32'h9ABCDEF0) $display("FAIL %s.hold_addr_data got %h/%h exp 1/9abcdef0", name, bus.mem_addr, bus.mem_wdata); else n_pass++;
  endtask

  task automatic test_zero_len();
    int base, cyc;
    base = we_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 1);
    wait_end(20, cyc);
    n_chk++; if (bus.done !== 1'b1) $display("FAIL zero.done got %b exp 1", bus.done); else n_pass++;
    n_chk++; if (bus.error !== 1'b0) $display("FAIL zero.error got %b exp 0", bus.error); else n_pass++;
    n_chk++; if (bus.cpu_hold !== 1'b0) $display("FAIL zero.cpu_hold got %b exp 0", bus.cpu_hold); else n_pass++;
    n_chk++; if (bus.words_written !== 16'd0) $display("FAIL zero.words_written got %0d exp 0", bus.words_written); else n_pass++;
    n_chk++; if (we_cnt != base) $display("FAIL zero.no_write got %0d writes exp 0", we_cnt - base); else n_pass++;
  endtask

  task automatic test_oversize();
    int base, cyc;
    base = we_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h11, 1);
    wait_end(20, cyc);
    n_chk++; if (bus.error !== 1'b1) $display("FAIL oversize.error got %b exp 1", bus.error); else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL oversize.done got %b exp 0", bus.done); else n_pass++;
    n_chk++; if (bus.cpu_hold !== 1'b1) $display("FAIL oversize.cpu_hold got %b exp 1", bus.cpu_hold); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL oversize.busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (we_cnt != base) $display("FAIL oversize.no_write got %0d writes exp 0", we_cnt - base); else n_pass++;
  endtask

  // 16 words exactly fills a 2^4-word memory and must be accepted.
  task automatic test_full_depth();
    int base, cyc;
    base = we_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h10, 0);
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) send(8'(w), 0);
    end
    wait_end(50, cyc);
    n_chk++; if (we_cnt - base !== 16) $display("FAIL full.write_count got %0d exp 16", we_cnt - base); else n_pass++;
    n_chk++; if (wr_data[base] !== 32'h00000000) $display("FAIL full.data0 got %h exp 00000000", wr_data[base]); else n_pass++;
    n_chk++; if (wr_addr[base+7] !== 4'd7 || wr_data[base+7] !== 32'h07070707) $display("FAIL full.word7 got %h/%h exp 7/07070707", wr_addr[base+7], wr_data[base+7]); else n_pass++;
    n_chk++; if (wr_addr[base+15] !== 4'd15 || wr_data[base+15] !== 32'h0F0F0F0F) $display("FAIL full.word15 got %h/%h exp f/0f0f0f0f", wr_addr[base+15], wr_data[base+15]); else n_pass++;
    n_chk++; if (bus.done !== 1'b1 || bus.error !== 1'b0) $display("FAIL full.status got done=%b err=%b exp 1/0", bus.done, bus.error); else n_pass++;
    n_chk++; if (bus.words_written !== 16'd16) $display("FAIL full.words_written got %0d exp 16", bus.words_written); else n_pass++;
  endtask

  task automatic test_timeout();
    int base, cyc;
    base = we_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    wait_end(60, cyc);
    n_chk++; if (bus.error !== 1'b1) $display("FAIL timeout.error got %b exp 1", bus.error); else n_pass++;
    n_chk++; if (cyc < 15 || cyc > 25) $display("FAIL timeout.latency got %0d exp 15..25", cyc); else n_pass++;
    n_chk++; if (bus.cpu_hold !== 1'b1) $display("FAIL timeout.cpu_hold got %b exp 1", bus.cpu_hold); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL timeout.busy_done got %b/%b exp 0/0", bus.busy, bus.done); else n_pass++;
    n_chk++; if (we_cnt != base) $display("FAIL timeout.no_write got %0d writes exp 0", we_cnt - base); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    base = we_cnt;
    pulse_start();
    send(8'h00, 0); send(8'h04, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h55, 0); send(8'h66, 0);
    reset = 1'b1;
    @(negedge clock);
    n_chk++; if (bus.busy !== 1'b0 || bus.cpu_hold !== 1'b0) $display("FAIL rstmid.busy_hold got %b/%b exp 0/0", bus.busy, bus.cpu_hold); else n_pass++;
    n_chk++; if (bus.done !== 1'b0 || bus.error !== 1'b0) $display("FAIL rstmid.done_err got %b/%b exp 0/0", bus.done, bus.error); else n_pass++;
    n_chk++; if (bus.words_written !== 16'd0 || bus.mem_we !== 1'b0) $display("FAIL rstmid.ww_we got %0d/%b exp 0/0", bus.words_written, bus.mem_we); else n_pass++;
    n_chk++; if (bus.mem_addr !== 4'd0 || bus.mem_wdata !== 32'd0) $display("FAIL rstmid.addr_data got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h70 + 8'(i), 0);
    repeat (5) @(negedge clock);
    n_chk++; if (we_cnt - base !== 1) $display("FAIL rstmid.write_count got %0d exp 1", we_cnt - base); else n_pass++;
    n_chk++; if (wr_addr[base] !== 4'd0 || wr_data[base] !== 32'h11223344) $display("FAIL rstmid.word0 got %h/%h exp 0/11223344", wr_addr[base], wr_data[base]); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rstmid.idle_busy got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_ignore();
    int base, cyc;
    base = we_cnt;
    pulse_start();
    send(8'h00, 1); send(8'h01, 1);
    send(8'hAA, 1);
    pulse_start();
    send(8'hBB, 1); send(8'hCC, 1); send(8'hDD, 1);
    wait_end(20, cyc);
    n_chk++; if (we_cnt - base !== 1) $display("FAIL ignore.write_count got %0d exp 1", we_cnt - base); else n_pass++;
    n_chk++; if (wr_addr[base] !== 4'd0 || wr_data[base] !== 32'hAABBCCDD) $display("FAIL ignore.word got %h/%h exp 0/aabbccdd", wr_addr[base], wr_data[base]); else n_pass++;
    n_chk++; if (bus.done !== 1'b1 || bus.error !== 1'b0) $display("FAIL ignore.status got done=%b err=%b exp 1/0", bus.done, bus.error); else n_pass++;
    for (int i = 0; i < 4; i++) send(8'h11 * 8'(i + 1), 0);
    repeat (3) @(negedge clock);
    n_chk++; if (we_cnt - base !== 1) $display("FAIL ignore.rx_in_done got %0d writes exp 1", we_cnt - base); else n_pass++;
    n_chk++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL ignore.done_state got done=%b busy=%b exp 1/0", bus.done, bus.busy); else n_pass++;
    n_chk++; if (bus.words_written !== 16'd1) $display("FAIL ignore.words_written got %0d exp 1", bus.words_written); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load("basic", 1);
    test_load("back_to_back", 0);
    test_load("spaced", 4);
    test_zero_len();
    test_oversize();
    test_full_depth();
    test_timeout();
    test_load("recover", 1);
    test_reset_mid();
    test_ignore();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

`default_nettype wire
